rtc_tick_gen: RTL
=================

Name: rtc_tick_gen

Overview:
- Multi-channel, parametrised successor to the single-output RTC divider.
- Each channel divides a qualified advance strobe (an external RTC edge pulse, or pclk in test mode) by a programmable value and emits one-cycle tick enables instead of gated clocks.
- Adds shadowed glitch-free reconfiguration, periodic/one-shot modes and per-channel status.
- Sits between the RTC clock synchroniser and the RTC counter/alarm and timer consumers; fully pclk-synchronous.

Parameters:
- CH_NUM, 4, number of independent divider channels (1..16).
- DIV_W, 20, divider width in bits; period = div+1 advances.

Ports:
- pclk  input  1  sole clock.
- preset  input  1  synchronous reset, active-high.
- test_mode  input  1  1: every pclk cycle is an advance, ext_tick ignored.
- ext_tick  input  1  one-pclk pulse per synchronised external RTC clock edge.
- ch_en  input  CH_NUM  per-channel enable (level).
- ch_oneshot  input  CH_NUM  per-channel mode: 0 periodic, 1 one-shot; sampled on ch_en rising edge.
- cfg_wr  input  CH_NUM  per-channel divider write strobe.
- cfg_div  input  CH_NUM*DIV_W  divider values; channel i at [i*DIV_W +: DIV_W].
- tick  output  CH_NUM  one-cycle tick pulse per channel.
- busy  output  CH_NUM  channel in RUN state.
- cfg_pend  output  CH_NUM  shadow value waiting for transfer.
- clk_out  output  CH_NUM  divided toggle output (see Optional Feature).

Behaviour:
- Reset (preset=1 at a pclk edge): cnt=0, div_act=0, div_shd=0, state=IDLE; tick, busy, cfg_pend, clk_out all 0.
- adv = test_mode | ext_tick (common to all channels).
- Per-channel FSM:
  - IDLE: cnt held at 0, tick=0.
  - IDLE -> RUN on the ch_en rising edge. Latch ch_oneshot into mode; cnt=0.
  - RUN: if adv and cnt!=div_act, cnt+1. If adv and cnt==div_act (terminal), cnt=0 and tick is asserted in the next cycle (registered, latency 1 pclk).
  - RUN -> DONE on the first terminal when mode=one-shot. Periodic channels stay in RUN.
  - DONE: tick=0, cnt=0; leave only when ch_en=0 (-> IDLE). Rearm needs a fresh ch_en rising edge.
  - Any state -> IDLE when ch_en=0 (mid-count abort, no tick). Abort takes priority over a terminal count in the same cycle.
- div_act=0: a tick follows every advance. div_act=all-ones: period is 2^DIV_W advances; cnt never overflows.
- Reconfiguration:
  - cfg_wr loads div_shd and sets cfg_pend.
  - Transfer div_shd -> div_act and clear cfg_pend at the next terminal in RUN, or immediately (next cycle) when the channel is in IDLE or DONE.
  - cfg_wr in the same cycle as a terminal: the new cfg_div goes straight to div_act and cfg_pend stays 0. The tick for that terminal still fires.
  - Back-to-back cfg_wr: the last write wins.
- busy = (state==RUN), registered.
- Channels are fully independent. A simultaneous terminal on several channels produces simultaneous ticks.

Optional Feature:
- Macro RTC_TICK_TOGGLE_EN.
- Defined: clk_out[i] toggles in the same cycle that tick[i] is asserted, giving a 50% duty output of period 2*(div_act+1) advances. It clears to 0 on reset and on entry to IDLE, and holds its value in DONE.
- Undefined: clk_out is tied to 0 and no toggle flops are built.

Decomposition:
- Package rtc_tick_pkg:
  - state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default DIV_W/CH_NUM constants.
  - slice helper for cfg_div indexing.
- Sub-module rtc_tick_chan: one channel (FSM, counter, shadow, toggle).
- rtc_tick_gen forms adv and generates CH_NUM instances.

Test Plan:
- test_mode=1, div=3, periodic, ch_en=1 -> tick every 4 pclk; first tick 5 cycles after ch_en rises (4 advances + 1 latency); busy=1.
- test_mode=0, ext_tick every 10 pclk, div=0 -> tick exactly 1 pclk after each ext_tick. With div=1 -> one tick per two ext_tick.
- One-shot, div=2, test_mode=1 -> exactly one tick, then busy=0 (state DONE). No further ticks until ch_en 1->0->1, which produces one more tick.
- Running div=9, cfg_wr div=2 mid-count -> cfg_pend=1, current period completes at 10; following periods are 3; cfg_pend clears at the transfer terminal. Also cover cfg_wr coincident with a terminal: the new value applies immediately and cfg_pend stays 0.
- ch_en dropped at cnt==div-1, and separately at cnt==div with adv -> no tick, cnt=0, busy=0. Then preset asserted during RUN -> all outputs 0 next cycle.
- RTC_TICK_TOGGLE_EN defined, div=4, test_mode=1 -> clk_out period 10 pclk, 50% duty, in phase with tick. Undefined -> clk_out constant 0.

Source files
------------

// File: rtl/rtc_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_tick_pkg
// Description : Shared types and constants for the RTC tick generator.
//               Optional build macro used by the slice: RTC_TICK_TOGGLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_tick_pkg;

    localparam int c_DEF_CH_NUM = 4;
    localparam int c_DEF_DIV_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } rtc_state_e;

    // LSB position of a channel's divider field in the packed cfg_div bus
    function automatic int cfg_lsb(input int ch, input int div_w);
        return ch * div_w;
    endfunction

endpackage : rtc_tick_pkg
`default_nettype wire

// File: rtl/rtc_tick_chan.sv
`default_nettype none
// ============================================================================
// Module      : rtc_tick_chan
// Description : One divider channel: FSM, counter, shadowed divider and an
//               optional toggle output (built only with RTC_TICK_TOGGLE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_tick_chan
    import rtc_tick_pkg::*;
#(
    parameter int DIV_W = c_DEF_DIV_W
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             i_adv,
    input  logic             i_ch_en,
    input  logic             i_oneshot,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_cfg_pend,
    output logic             o_clk_out
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    rtc_state_e       r_state;
    rtc_state_e       w_state_nxt;
    logic             r_en_d;
    logic             r_mode;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_shd;
    logic             r_pend;
    logic             r_tick;
    logic             r_busy;
    logic             w_rise;
    logic             w_term;

    assign w_rise = i_ch_en & ~r_en_d;
    // Qualified by ch_en so that an abort wins over a coincident terminal
    assign w_term = (r_state == RUN) & i_ch_en & i_adv & (r_cnt == r_div_act);

    always_comb begin
        w_state_nxt = r_state;
        if (!i_ch_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rise) w_state_nxt = RUN;
                RUN:     if (w_term && r_mode) w_state_nxt = DONE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_en_d    <= 1'b0;
            r_mode    <= 1'b0;
            r_cnt     <= '0;
            r_div_act <= '0;
            r_div_shd <= '0;
            r_pend    <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_en_d <= i_ch_en;
            r_tick <= w_term;
            r_busy <= (w_state_nxt == RUN);

            if (r_state == IDLE && w_rise) begin
                r_mode <= i_oneshot;
            end

            if (r_state == RUN && w_state_nxt == RUN) begin
                if (i_adv) begin
                    r_cnt <= w_term ? '0 : r_cnt + c_ONE;
                end
            end else begin
                r_cnt <= '0;
            end

            // A write landing on a terminal bypasses the shadow entirely
            if (i_cfg_wr) begin
                r_div_shd <= i_cfg_div;
                if (w_term) begin
                    r_div_act <= i_cfg_div;
                    r_pend    <= 1'b0;
                end else begin
                    r_pend    <= 1'b1;
                end
            end else if (r_pend && (w_term || r_state != RUN)) begin
                r_div_act <= r_div_shd;
                r_pend    <= 1'b0;
            end
        end
    end

`ifdef RTC_TICK_TOGGLE_EN
    logic r_clk_out;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_clk_out <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_clk_out <= 1'b0;
        end else if (w_term) begin
            r_clk_out <= ~r_clk_out;
        end
    end

    assign o_clk_out = r_clk_out;
`else
    assign o_clk_out = 1'b0;
`endif

    assign o_tick     = r_tick;
    assign o_busy     = r_busy;
    assign o_cfg_pend = r_pend;

endmodule : rtc_tick_chan
`default_nettype wire

// File: rtl/rtc_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : rtc_tick_gen
// Description : Multi-channel RTC tick-enable generator. Optional toggle
//               outputs are built when RTC_TICK_TOGGLE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_tick_gen
    import rtc_tick_pkg::*;
#(
    parameter int CH_NUM = c_DEF_CH_NUM,
    parameter int DIV_W  = c_DEF_DIV_W
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    test_mode,
    input  logic                    ext_tick,
    input  logic [CH_NUM-1:0]       ch_en,
    input  logic [CH_NUM-1:0]       ch_oneshot,
    input  logic [CH_NUM-1:0]       cfg_wr,
    input  logic [CH_NUM*DIV_W-1:0] cfg_div,
    output logic [CH_NUM-1:0]       tick,
    output logic [CH_NUM-1:0]       busy,
    output logic [CH_NUM-1:0]       cfg_pend,
    output logic [CH_NUM-1:0]       clk_out
);

    logic w_adv;

    // Test mode turns every pclk cycle into an advance
    assign w_adv = test_mode | ext_tick;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
            rtc_tick_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .pclk       (pclk),
                .preset     (preset),
                .i_adv      (w_adv),
                .i_ch_en    (ch_en[gi]),
                .i_oneshot  (ch_oneshot[gi]),
                .i_cfg_wr   (cfg_wr[gi]),
                .i_cfg_div  (cfg_div[cfg_lsb(gi, DIV_W) +: DIV_W]),
                .o_tick     (tick[gi]),
                .o_busy     (busy[gi]),
                .o_cfg_pend (cfg_pend[gi]),
                .o_clk_out  (clk_out[gi])
            );
        end
    endgenerate

endmodule : rtc_tick_gen
`default_nettype wire
